lcd_text_ctrl: RTL

- Sequencer for a 2x16 HD44780-style character LCD in 8-bit write-only mode.
- Paced entirely by the periodic one-cycle enable tick from the LCD tick generator.
- Runs the power-up delay and the init command sequence, then continuously refreshes both lines from a 32-entry character source, such as the clock/time formatter.

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/lcd_xfer_phase.sv | 49 ++++
 rtl/lcd_text_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, command bytes and geometry for the 2x16 text LCD sequencer
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_FUNC_SET,
    ST_DISP_CTRL,
    ST_ENTRY,
    ST_CLEAR,
    ST_L1_ADDR,
    ST_L1_CHAR,
    ST_L2_ADDR,
    ST_L2_CHAR,
    ST_IDLE
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int LCD_COLS  = 16;
  localparam int LCD_CHARS = 32;

endpackage

// File: rtl/lcd_xfer_phase.sv
// rtl/lcd_xfer_phase.sv - two-tick strobe generator for one LCD command or data byte
//
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   en_clk        pacing tick; nothing changes on cycles without it
//   start         a transfer is wanted; accepted on a tick while idle (phase 0)
//   rs, tx_byte   register select and byte captured on the accepting tick
//   lcd_e         strobe: high for the phase-0 tick, low from the phase-1 tick
//   lcd_rs        captured register select, held until the next transfer
//   lcd_data      captured byte, held until the next transfer
//   done          combinational, high on the tick that ends phase 1
module lcd_xfer_phase (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_clk,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] tx_byte,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  logic phase;

  assign done = en_clk & phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (en_clk) begin
      if (phase) begin
        // Falling edge of E is where the LCD latches; rs/data stay put.
        lcd_e <= 1'b0;
        phase <= 1'b0;
      end else if (start) begin
        lcd_e    <= 1'b1;
        lcd_rs   <= rs;
        lcd_data <= tx_byte;
        phase    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780 2x16 init and continuous refresh sequencer, 8-bit write-only
//
// Optional feature macro: LCD_FRAME_SYNC_EN (adds frame_req/frame_done and an IDLE
// state between frames; without it frames free-run).
//
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   en_clk        one-clk pacing tick; all state changes happen only on it
//   char_data     ASCII for char_addr, sampled on the tick starting that character
//   frame_req     (macro only) permission to start the next frame, seen on a tick
//   frame_done    (macro only) one-clk pulse on the tick ending character 31
//   char_addr     character index, 0-15 line 1, 16-31 line 2, 0 outside char states
//   init_done     high after the clear command completes, until reset
//   lcd_e, lcd_rs, lcd_rw, lcd_data   LCD bus (rw tied low)
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int         POWERUP_TICKS = 20,
  parameter logic [7:0] ENTRY_MODE    = 8'h06,
  parameter logic [7:0] DISP_CTRL     = 8'h0C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_clk,
  input  logic [7:0] char_data,
`ifdef LCD_FRAME_SYNC_EN
  input  logic       frame_req,
  output logic       frame_done,
`endif
  output logic [4:0] char_addr,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam logic [15:0] PWR_LAST  = 16'(POWERUP_TICKS);
  localparam logic [4:0]  LAST_L1   = 5'(LCD_COLS - 1);
  localparam logic [4:0]  FIRST_L2  = 5'(LCD_COLS);
  localparam logic [4:0]  LAST_CHAR = 5'(LCD_CHARS - 1);

  lcd_state_t  state, next_state;
  logic [15:0] pwr_cnt;
  logic        xfer_start, xfer_rs, xfer_done;
  logic [7:0]  xfer_byte;

  assign lcd_rw = 1'b0;

`ifdef LCD_FRAME_SYNC_EN
  assign frame_done = xfer_done && (state == ST_L2_CHAR) && (char_addr == LAST_CHAR);
`endif

  lcd_xfer_phase u_xfer (
    .clk      (clk),
    .rst      (rst),
    .en_clk   (en_clk),
    .start    (xfer_start),
    .rs       (xfer_rs),
    .tx_byte  (xfer_byte),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .done     (xfer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_PWR_WAIT;
    else      state <= next_state;
  end

  // Every transfer state keeps start asserted, so the strobe generator begins
  // the next byte on the tick right after the previous phase 1: no idle ticks.
  always_comb begin
    next_state = state;
    xfer_start = 1'b0;
    xfer_rs    = 1'b0;
    xfer_byte  = 8'h00;
    case (state)
      ST_PWR_WAIT: begin
        if (en_clk && (pwr_cnt + 16'd1 >= PWR_LAST)) next_state = ST_FUNC_SET;
      end
      ST_FUNC_SET: begin
        xfer_start = 1'b1;
        xfer_byte  = CMD_FUNC_SET;
        if (xfer_done) next_state = ST_DISP_CTRL;
      end
      ST_DISP_CTRL: begin
        xfer_start = 1'b1;
        xfer_byte  = DISP_CTRL;
        if (xfer_done) next_state = ST_ENTRY;
      end
      ST_ENTRY: begin
        xfer_start = 1'b1;
        xfer_byte  = ENTRY_MODE;
        if (xfer_done) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        xfer_start = 1'b1;
        xfer_byte  = CMD_CLEAR;
        if (xfer_done) next_state = ST_L1_ADDR;
      end
      ST_L1_ADDR: begin
        xfer_start = 1'b1;
        xfer_byte  = CMD_LINE1;
        if (xfer_done) next_state = ST_L1_CHAR;
      end
      ST_L1_CHAR: begin
        xfer_start = 1'b1;
        xfer_rs    = 1'b1;
        xfer_byte  = char_data;
        if (xfer_done && (char_addr == LAST_L1)) next_state = ST_L2_ADDR;
      end
      ST_L2_ADDR: begin
        xfer_start = 1'b1;
        xfer_byte  = CMD_LINE2;
        if (xfer_done) next_state = ST_L2_CHAR;
      end
      ST_L2_CHAR: begin
        xfer_start = 1'b1;
        xfer_rs    = 1'b1;
        xfer_byte  = char_data;
`ifdef LCD_FRAME_SYNC_EN
        if (xfer_done && (char_addr == LAST_CHAR)) next_state = ST_IDLE;
`else
        if (xfer_done && (char_addr == LAST_CHAR)) next_state = ST_L1_ADDR;
`endif
      end
`ifdef LCD_FRAME_SYNC_EN
      // The line-1 address command is launched on the very tick frame_req is
      // seen, so the IDLE tick doubles as that command's phase 0.
      ST_IDLE: begin
        if (frame_req) begin
          xfer_start = 1'b1;
          xfer_byte  = CMD_LINE1;
          if (en_clk) next_state = ST_L1_ADDR;
        end
      end
`endif
      default: next_state = ST_PWR_WAIT;
    endcase
  end

  // char_addr moves at the end of the preceding transfer, giving the source a
  // full tick to settle before the character's phase-0 sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwr_cnt   <= 16'd0;
      char_addr <= 5'd0;
      init_done <= 1'b0;
    end else if (en_clk) begin
      if (state == ST_PWR_WAIT) pwr_cnt <= pwr_cnt + 16'd1;
      if (xfer_done) begin
        case (state)
          ST_CLEAR:   init_done <= 1'b1;
          ST_L1_CHAR: char_addr <= (char_addr == LAST_L1) ? 5'd0 : char_addr + 5'd1;
          ST_L2_ADDR: char_addr <= FIRST_L2;
          ST_L2_CHAR: char_addr <= (char_addr == LAST_CHAR) ? 5'd0 : char_addr + 5'd1;
          default:    ;
        endcase
      end
    end
  end

endmodule
